// File: rtl/shift_seq_unit_if.sv
// Request/result bundle between the multicycle control unit and the
// sequential shifter: operand, shift type and amount go in with a start
// pulse; the working register, busy and done come back.
interface shift_seq_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         shift_ctrl;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   shift_src;
    logic [WIDTH-1:0]   shift_out;
    logic               busy;
    logic               done;

    // Control unit side: issues requests, observes the result.
    modport master (
        output start,
        output shift_ctrl,
        output shamt,
        output shift_src,
        input  shift_out,
        input  busy,
        input  done
    );

    // Shifter side: accepts requests, drives the result.
    modport slave (
        input  start,
        input  shift_ctrl,
        input  shamt,
        input  shift_src,
        output shift_out,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_seq_unit.sv
// Sequential shifter for the multicycle MIPS datapath. One bit position is
// shifted per clock (SLL/SRL/SRA/ROR, same 2-bit encoding as the
// combinational shifter). The result stays in shift_out until the next
// accepted start; done pulses for one cycle when it is final.
module shift_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    shift_seq_unit_if.slave bus
);

    localparam logic [1:0] CTRL_SLL = 2'b00;
    localparam logic [1:0] CTRL_SRL = 2'b01;
    localparam logic [1:0] CTRL_SRA = 2'b10;
    localparam logic [1:0] CTRL_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] COUNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] COUNT_ONE  = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   result;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         ctrl;

    // Single-position shift of the working value according to the latched type.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] value,
        input logic [1:0]       op
    );
        logic signed [WIDTH-1:0] sval;
        logic        [WIDTH-1:0] step;
        sval = signed'(value);
        step = value;
        case (op)
            CTRL_SLL: step = {value[WIDTH-2:0], 1'b0};
            CTRL_SRL: step = {1'b0, value[WIDTH-1:1]};
            CTRL_SRA: step = unsigned'(sval >>> 1);
            CTRL_ROR: step = {value[0], value[WIDTH-1:1]};
            default:  step = value;
        endcase
        return step;
    endfunction

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: shamt of zero skips straight to DONE, otherwise the
    // last shift happens on the edge where count is still one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.shamt == COUNT_ZERO) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == COUNT_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/type/amount latch on accepted start, one-bit shift per SHIFT
    // cycle; everything else holds so the result stays put for write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
            count  <= '0;
            ctrl   <= CTRL_SLL;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        result <= bus.shift_src;
                        count  <= bus.shamt;
                        ctrl   <= bus.shift_ctrl;
                    end
                end
                SHIFT: begin
                    result <= shift_step(result, ctrl);
                    count  <= count - COUNT_ONE;
                end
                default: begin
                    result <= result;
                    count  <= count;
                end
            endcase
        end
    end

    assign bus.shift_out = result;
    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: hand-computed vectors for each shift
// type, boundary amounts, ignored start pulses and asynchronous reset.
module tb_shift_seq_unit;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    shift_seq_unit_if #(.WIDTH(32), .SHAMT_W(5)) sif ();

    shift_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request from IDLE and measure it: result at done, number of
    // cycles from the start edge to done (1 = done right after the start
    // edge), busy cycles seen, and whether the unit is back in IDLE holding
    // the result one edge later. Inputs are scrambled after the start edge.
    task automatic do_op(input logic [31:0] src, input logic [1:0] ctl,
                         input logic [4:0] amt, output logic [31:0] res,
                         output int lat, output int busy_n, output bit idle_ok);
        @(negedge clk);
        sif.start      = 1'b1;
        sif.shift_src  = src;
        sif.shift_ctrl = ctl;
        sif.shamt      = amt;
        @(posedge clk);
        #1;
        sif.start      = 1'b0;
        sif.shift_src  = ~src;
        sif.shift_ctrl = ~ctl;
        sif.shamt      = ~amt;
        lat    = 1;
        busy_n = 0;
        while (!sif.done && lat < 100) begin
            if (sif.busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = sif.shift_out;
        @(posedge clk);
        #1;
        idle_ok = (sif.done == 1'b0) && (sif.busy == 1'b0) && (sif.shift_out === res);
    endtask

    task automatic test_reset;
        logic [31:0] res;
        int lat, bn;
        bit ok;
        sif.start = 1'b0; sif.shift_src = '0; sif.shift_ctrl = 2'b00; sif.shamt = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_op(32'd10, 2'b00, 5'd1, res, lat, bn, ok);
        checks++;
        if (res !== 32'd20) begin
            errors++; $display("FAIL reset_preload: shift_out=%h expected=%h", res, 32'd20);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (sif.shift_out !== 32'd0 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: shift_out=%h busy=%b done=%b expected 0/0/0",
                     sif.shift_out, sif.busy, sif.done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (sif.shift_out !== 32'd0 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: shift_out=%h busy=%b done=%b expected 0/0/0",
                         i, sif.shift_out, sif.busy, sif.done);
            end
        end
    endtask

    task automatic test_sll;
        logic [4:0]  amts [3] = '{5'd3, 5'd1, 5'd2};
        logic [31:0] exps [3] = '{32'd80, 32'd20, 32'd40};
        logic [31:0] res;
        int lat, bn;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_op(32'd10, 2'b00, amts[i], res, lat, bn, ok);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL sll_result[%0d]: got=%h expected=%h", i, res, exps[i]);
            end
            checks++;
            if (lat != int'(amts[i]) + 1 || bn != int'(amts[i])) begin
                errors++;
                $display("FAIL sll_timing[%0d]: latency=%0d busy=%0d expected %0d/%0d",
                         i, lat, bn, int'(amts[i]) + 1, int'(amts[i]));
            end
            checks++;
            if (!ok) begin
                errors++; $display("FAIL sll_hold[%0d]: idle_hold=%0b expected 1", i, ok);
            end
        end
    endtask

    task automatic test_srl;
        logic [4:0]  amts [3] = '{5'd1, 5'd10, 5'd31};
        logic [31:0] exps [3] = '{32'h7FFF_FFF7, 32'h003F_FFFF, 32'h0000_0001};
        logic [31:0] res;
        int lat, bn;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_op(32'hFFFF_FFEF, 2'b01, amts[i], res, lat, bn, ok);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL srl_result[%0d]: got=%h expected=%h", i, res, exps[i]);
            end
            checks++;
            if (lat != int'(amts[i]) + 1 || bn != int'(amts[i]) || !ok) begin
                errors++;
                $display("FAIL srl_timing[%0d]: latency=%0d busy=%0d hold=%0b expected %0d/%0d/1",
                         i, lat, bn, ok, int'(amts[i]) + 1, int'(amts[i]));
            end
        end
    endtask

    task automatic test_sra;
        logic [4:0]  amts [3] = '{5'd1, 5'd10, 5'd31};
        logic [31:0] exps [3] = '{32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat, bn;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_op(32'hFFFF_FFEF, 2'b10, amts[i], res, lat, bn, ok);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL sra_result[%0d]: got=%h expected=%h", i, res, exps[i]);
            end
            checks++;
            if (lat != int'(amts[i]) + 1 || bn != int'(amts[i]) || !ok) begin
                errors++;
                $display("FAIL sra_timing[%0d]: latency=%0d busy=%0d hold=%0b expected %0d/%0d/1",
                         i, lat, bn, ok, int'(amts[i]) + 1, int'(amts[i]));
            end
        end
    endtask

    task automatic test_boundary;
        logic [31:0] srcs [4] = '{32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001};
        logic [1:0]  ctls [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
        logic [4:0]  amts [4] = '{5'd0, 5'd1, 5'd4, 5'd31};
        logic [31:0] exps [4] = '{32'h1234_5678, 32'h8000_0000, 32'h8123_4567, 32'h8000_0000};
        logic [31:0] res;
        int lat, bn;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(srcs[i], ctls[i], amts[i], res, lat, bn, ok);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL boundary_result[%0d]: got=%h expected=%h", i, res, exps[i]);
            end
            checks++;
            if (lat != int'(amts[i]) + 1 || bn != int'(amts[i]) || !ok) begin
                errors++;
                $display("FAIL boundary_timing[%0d]: latency=%0d busy=%0d hold=%0b expected %0d/%0d/1",
                         i, lat, bn, ok, int'(amts[i]) + 1, int'(amts[i]));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res_a, res_b;
        int lat_a, lat_b, bn_a, bn_b;
        bit ok_a, ok_b;
        do_op(32'h8000_0000, 2'b10, 5'd4, res_a, lat_a, bn_a, ok_a);
        do_op(32'h0000_0003, 2'b00, 5'd2, res_b, lat_b, bn_b, ok_b);
        checks++;
        if (res_a !== 32'hF800_0000) begin
            errors++; $display("FAIL b2b_first: got=%h expected=%h", res_a, 32'hF800_0000);
        end
        checks++;
        if (res_b !== 32'h0000_000C || lat_b != 3 || bn_b != 2) begin
            errors++;
            $display("FAIL b2b_second: got=%h latency=%0d busy=%0d expected %h/3/2",
                     res_b, lat_b, bn_b, 32'h0000_000C);
        end
    endtask

    task automatic test_protocol;
        int lat;
        @(negedge clk);
        sif.start = 1'b1; sif.shift_src = 32'h1; sif.shift_ctrl = 2'b00; sif.shamt = 5'd4;
        @(posedge clk);
        @(negedge clk);
        sif.shift_src = 32'h0000_FFFF;
        sif.shamt     = 5'd2;
        lat = 1;
        while (!sif.done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (sif.shift_out !== 32'h10 || lat != 5) begin
            errors++;
            $display("FAIL protocol_result: shift_out=%h latency=%0d expected %h/5",
                     sif.shift_out, lat, 32'h10);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        checks++;
        if (sif.shift_out !== 32'h10 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL protocol_after_done: shift_out=%h busy=%b done=%b expected %h/0/0",
                     sif.shift_out, sif.busy, sif.done, 32'h10);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sif.shift_out !== 32'h10 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL protocol_idle_hold: shift_out=%h busy=%b done=%b expected %h/0/0",
                     sif.shift_out, sif.busy, sif.done, 32'h10);
        end
    endtask

    task automatic test_reset_mid_op;
        bit seen_done;
        bit seen_busy;
        @(negedge clk);
        sif.start = 1'b1; sif.shift_src = 32'h1; sif.shift_ctrl = 2'b00; sif.shamt = 5'd8;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (sif.shift_out !== 32'h40 || sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_progress: shift_out=%h busy=%b expected %h/1",
                     sif.shift_out, sif.busy, 32'h40);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (sif.shift_out !== 32'd0 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: shift_out=%h busy=%b done=%b expected 0/0/0",
                     sif.shift_out, sif.busy, sif.done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (sif.done) seen_done = 1'b1;
            if (sif.busy) seen_busy = 1'b1;
        end
        checks++;
        if (seen_done || seen_busy || sif.shift_out !== 32'd0) begin
            errors++;
            $display("FAIL midop_no_done: done_seen=%0b busy_seen=%0b shift_out=%h expected 0/0/0",
                     seen_done, seen_busy, sif.shift_out);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_srl();
        test_sra();
        test_boundary();
        test_back_to_back();
        test_protocol();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
